// File: rtl/rtc_timekeeper_pkg.sv
// rtc_pkg: shared constants and conversion helpers for the RTC timekeeper.
//   SEC_MAX / MIN_MAX / HR24_MAX : last legal value of each time field
//   RESET_HOUR                   : hour loaded by reset (legacy 12:00:00)
//   bin2bcd8                     : 0..99 binary -> packed two-digit BCD
//   hr24_to_hr12                 : 0..23 hour -> 1..12 display hour
package rtc_pkg;

  localparam logic [5:0] SEC_MAX    = 6'd59;
  localparam logic [5:0] MIN_MAX    = 6'd59;
  localparam logic [4:0] HR24_MAX   = 5'd23;
  localparam logic [4:0] RESET_HOUR = 5'd12;

  // Repeated subtraction keeps the logic small; input never exceeds 99,
  // so at most nine subtractions are needed.
  function automatic logic [7:0] bin2bcd8(input logic [6:0] v);
    logic [6:0] rem;
    logic [3:0] tens;
    rem  = v;
    tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  // Midnight and noon both display as 12.
  function automatic logic [4:0] hr24_to_hr12(input logic [4:0] h);
    logic [4:0] r;
    if (h == 5'd0)       r = 5'd12;
    else if (h > 5'd12)  r = h - 5'd12;
    else                 r = h;
    return r;
  endfunction

endpackage

// File: rtl/rtc_timekeeper_if.sv
// rtc_timekeeper_if: time-set port.
// Handshake: set_valid is a single-cycle request; it is always accepted in
// the cycle it is high (no ready). If any field is out of range the request
// is discarded and set_err pulses for one cycle in the following cycle.
//   set_valid  request     set_hh/mm/ss  binary time to load
//   set_err    out-of-range indication (slave -> master)
interface rtc_timekeeper_if;
  logic       set_valid;
  logic [4:0] set_hh;
  logic [5:0] set_mm;
  logic [5:0] set_ss;
  logic       set_err;

  modport master (output set_valid, set_hh, set_mm, set_ss, input set_err);
  modport slave  (input set_valid, set_hh, set_mm, set_ss, output set_err);
endinterface

// File: rtl/rtc_timekeeper_prescaler.sv
// rtc_prescaler: divides enabled clock cycles down to one-second ticks.
//   clk, reset : clock, async active-high reset
//   ena        : count enable; low holds the count
//   clear      : synchronous return to zero (used by a time load)
//   tick       : combinational, high in the cycle the count wraps
module rtc_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic ena,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = ena && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_cnt <= '0;
    else if (clear) r_cnt <= '0;
    else if (ena)   r_cnt <= tick ? '0 : r_cnt + CW'(1);
  end

endmodule

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: binary 24-hour h/m/s timekeeper with prescaler, validated
// load port, minute-resolution alarm and 12/24-hour (optionally BCD) display.
//   clk, reset        : clock, async active-high reset
//   ena               : prescaler enable
//   mode24            : 1 = 24-hour display, 0 = 12-hour display
//   set_if            : time-set port (slave)
//   alarm_en/hh/mm    : alarm enable and target time
//   hh, mm, ss, pm    : display outputs, combinational from registered state
//   sec_pulse, alarm, day_pulse : registered one-cycle event pulses
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int DIV = 1,
  parameter bit BCD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       mode24,
  rtc_timekeeper_if.slave set_if,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hh,
  input  logic [5:0] alarm_mm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       sec_pulse,
  output logic       alarm,
  output logic       day_pulse
);

  logic [4:0] r_h;
  logic [5:0] r_m, r_s;
  logic       r_sec_pulse, r_alarm, r_day_pulse, r_set_err;

  logic       w_tick, w_set_ok, w_set_bad;
  logic [4:0] w_h_n, w_hr_disp;
  logic [5:0] w_m_n, w_s_n;
  logic       w_day;

  assign w_set_ok  = set_if.set_valid && (set_if.set_hh <= HR24_MAX) &&
                     (set_if.set_mm <= MIN_MAX) && (set_if.set_ss <= SEC_MAX);
  assign w_set_bad = set_if.set_valid && !w_set_ok;

  rtc_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .ena   (ena),
    .clear (w_set_ok),
    .tick  (w_tick)
  );

  // Time one second after the current registered time.
  always_comb begin
    w_s_n = r_s + 6'd1;
    w_m_n = r_m;
    w_h_n = r_h;
    w_day = 1'b0;
    if (r_s == SEC_MAX) begin
      w_s_n = 6'd0;
      if (r_m == MIN_MAX) begin
        w_m_n = 6'd0;
        if (r_h == HR24_MAX) begin
          w_h_n = 5'd0;
          w_day = 1'b1;
        end else begin
          w_h_n = r_h + 5'd1;
        end
      end else begin
        w_m_n = r_m + 6'd1;
      end
    end
  end

  // A valid load wins over a same-cycle tick; the tick is discarded and
  // no event pulses are raised for that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h         <= RESET_HOUR;
      r_m         <= 6'd0;
      r_s         <= 6'd0;
      r_sec_pulse <= 1'b0;
      r_alarm     <= 1'b0;
      r_day_pulse <= 1'b0;
      r_set_err   <= 1'b0;
    end else begin
      r_set_err <= w_set_bad;
      if (w_set_ok) begin
        r_h         <= set_if.set_hh;
        r_m         <= set_if.set_mm;
        r_s         <= set_if.set_ss;
        r_sec_pulse <= 1'b0;
        r_alarm     <= 1'b0;
        r_day_pulse <= 1'b0;
      end else if (w_tick) begin
        r_h         <= w_h_n;
        r_m         <= w_m_n;
        r_s         <= w_s_n;
        r_sec_pulse <= 1'b1;
        r_day_pulse <= w_day;
        r_alarm     <= alarm_en && (w_h_n == alarm_hh) &&
                       (w_m_n == alarm_mm) && (w_s_n == 6'd0);
      end else begin
        r_sec_pulse <= 1'b0;
        r_alarm     <= 1'b0;
        r_day_pulse <= 1'b0;
      end
    end
  end

  assign w_hr_disp = mode24 ? r_h : hr24_to_hr12(r_h);

  assign hh = BCD ? bin2bcd8({2'b00, w_hr_disp}) : {3'b000, w_hr_disp};
  assign mm = BCD ? bin2bcd8({1'b0, r_m})        : {2'b00, r_m};
  assign ss = BCD ? bin2bcd8({1'b0, r_s})        : {2'b00, r_s};
  assign pm = (r_h >= 5'd12);

  assign sec_pulse      = r_sec_pulse;
  assign alarm          = r_alarm;
  assign day_pulse      = r_day_pulse;
  assign set_if.set_err = r_set_err;

endmodule

// File: tb/tb_rtc_timekeeper.sv
module tb_rtc_timekeeper;

  localparam int DIV_A = 4;

  logic clk, reset;
  logic mode24;
  logic ena_a, alarm_en_a;
  logic [4:0] alarm_hh_a;
  logic [5:0] alarm_mm_a;
  logic [7:0] hh_a, mm_a, ss_a;
  logic pm_a, sec_a, alarm_a, day_a;

  logic ena_b;
  logic [7:0] hh_b, mm_b, ss_b;
  logic pm_b, sec_b, alarm_b, day_b;

  int n_checks;
  int n_pass;

  rtc_timekeeper_if set_a ();
  rtc_timekeeper_if set_b ();

  // Binary display, DIV=4
  rtc_timekeeper #(.DIV(DIV_A), .BCD(1'b0)) dut_a (
    .clk(clk), .reset(reset), .ena(ena_a), .mode24(mode24), .set_if(set_a.slave),
    .alarm_en(alarm_en_a), .alarm_hh(alarm_hh_a), .alarm_mm(alarm_mm_a),
    .hh(hh_a), .mm(mm_a), .ss(ss_a), .pm(pm_a),
    .sec_pulse(sec_a), .alarm(alarm_a), .day_pulse(day_a)
  );

  // BCD display, DIV=1
  rtc_timekeeper #(.DIV(1), .BCD(1'b1)) dut_b (
    .clk(clk), .reset(reset), .ena(ena_b), .mode24(mode24), .set_if(set_b.slave),
    .alarm_en(1'b0), .alarm_hh(5'd0), .alarm_mm(6'd0),
    .hh(hh_b), .mm(mm_b), .ss(ss_b), .pm(pm_b),
    .sec_pulse(sec_b), .alarm(alarm_b), .day_pulse(day_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    set_a.set_valid = 1'b1;
    set_a.set_hh = h;
    set_a.set_mm = m;
    set_a.set_ss = s;
    step();
    set_a.set_valid = 1'b0;
  endtask

  // Prescaler is at zero after a load, so DIV enabled cycles give one advance.
  task automatic tick_a();
    ena_a = 1'b1;
    repeat (DIV_A) step();
    ena_a = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    #1;
    mode24 = 1'b0;
    #1;
    n_checks++; if (hh_a !== 8'd12) $display("FAIL reset_hh12 got %0d exp 12", hh_a); else n_pass++;
    n_checks++; if (mm_a !== 8'd0 || ss_a !== 8'd0) $display("FAIL reset_mmss got %0d:%0d exp 0:0", mm_a, ss_a); else n_pass++;
    n_checks++; if (pm_a !== 1'b1) $display("FAIL reset_pm got %b exp 1", pm_a); else n_pass++;
    n_checks++; if ({sec_a, alarm_a, day_a, set_a.set_err} !== 4'b0) $display("FAIL reset_pulses got %b exp 0000", {sec_a, alarm_a, day_a, set_a.set_err}); else n_pass++;
    n_checks++; if (hh_b !== 8'h12) $display("FAIL reset_bcd_hh got %h exp 12", hh_b); else n_pass++;
    mode24 = 1'b1;
    #1;
    n_checks++; if (hh_a !== 8'd12) $display("FAIL reset_hh24 got %0d exp 12", hh_a); else n_pass++;
    mode24 = 1'b0;
  endtask

  task automatic test_prescaler();
    int pulses;
    pulses = 0;
    ena_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (sec_a === 1'b1) pulses++;
    end
    ena_a = 1'b0;
    n_checks++; if (ss_a !== 8'd2) $display("FAIL presc_ss got %0d exp 2", ss_a); else n_pass++;
    n_checks++; if (pulses !== 2) $display("FAIL presc_pulses got %0d exp 2", pulses); else n_pass++;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sec_a === 1'b1) pulses++;
    end
    n_checks++; if (ss_a !== 8'd2 || mm_a !== 8'd0) $display("FAIL hold_time got %0d:%0d exp 0:2", mm_a, ss_a); else n_pass++;
    n_checks++; if (pulses !== 0) $display("FAIL hold_pulses got %0d exp 0", pulses); else n_pass++;
  endtask

  task automatic test_day_rollover();
    set_a_time(5'd23, 6'd59, 6'd59);
    n_checks++; if (hh_a !== 8'd11 || pm_a !== 1'b1) $display("FAIL load_2359 got hh=%0d pm=%b exp hh=11 pm=1", hh_a, pm_a); else n_pass++;
    tick_a();
    n_checks++; if (hh_a !== 8'd12 || mm_a !== 8'd0 || ss_a !== 8'd0) $display("FAIL midnight_12h got %0d:%0d:%0d exp 12:0:0", hh_a, mm_a, ss_a); else n_pass++;
    n_checks++; if (day_a !== 1'b1 || sec_a !== 1'b1 || pm_a !== 1'b0) $display("FAIL midnight_flags got day=%b sec=%b pm=%b exp 1 1 0", day_a, sec_a, pm_a); else n_pass++;
    mode24 = 1'b1;
    #1;
    n_checks++; if (hh_a !== 8'd0) $display("FAIL midnight_24h got %0d exp 0", hh_a); else n_pass++;
    mode24 = 1'b0;
    step();
    n_checks++; if (day_a !== 1'b0 || sec_a !== 1'b0) $display("FAIL day_pulse_width got day=%b sec=%b exp 0 0", day_a, sec_a); else n_pass++;
  endtask

  task automatic test_noon();
    set_a_time(5'd11, 6'd59, 6'd59);
    tick_a();
    n_checks++; if (hh_a !== 8'd12 || pm_a !== 1'b1) $display("FAIL noon got hh=%0d pm=%b exp 12 1", hh_a, pm_a); else n_pass++;
    n_checks++; if (day_a !== 1'b0) $display("FAIL noon_day got %b exp 0", day_a); else n_pass++;
    set_a_time(5'd12, 6'd59, 6'd59);
    tick_a();
    n_checks++; if (hh_a !== 8'd1 || pm_a !== 1'b1 || mm_a !== 8'd0) $display("FAIL one_pm got hh=%0d mm=%0d pm=%b exp 1 0 1", hh_a, mm_a, pm_a); else n_pass++;
    mode24 = 1'b1;
    #1;
    n_checks++; if (hh_a !== 8'd13) $display("FAIL one_pm_24h got %0d exp 13", hh_a); else n_pass++;
    mode24 = 1'b0;
  endtask

  task automatic test_alarm();
    alarm_hh_a = 5'd7;
    alarm_mm_a = 6'd30;
    alarm_en_a = 1'b1;
    set_a_time(5'd7, 6'd29, 6'd59);
    tick_a();
    n_checks++; if (alarm_a !== 1'b1) $display("FAIL alarm_fire got %b exp 1", alarm_a); else n_pass++;
    step();
    n_checks++; if (alarm_a !== 1'b0) $display("FAIL alarm_width got %b exp 0", alarm_a); else n_pass++;
    set_a_time(5'd7, 6'd30, 6'd0);
    n_checks++; if (alarm_a !== 1'b0 || mm_a !== 8'd30) $display("FAIL alarm_by_set got alarm=%b mm=%0d exp 0 30", alarm_a, mm_a); else n_pass++;
    alarm_en_a = 1'b0;
    set_a_time(5'd7, 6'd29, 6'd59);
    tick_a();
    n_checks++; if (alarm_a !== 1'b0 || sec_a !== 1'b1) $display("FAIL alarm_disabled got alarm=%b sec=%b exp 0 1", alarm_a, sec_a); else n_pass++;
  endtask

  task automatic test_set_error();
    // time is 07:30:00 here
    set_a_time(5'd9, 6'd60, 6'd0);
    n_checks++; if (set_a.set_err !== 1'b1) $display("FAIL set_err_pulse got %b exp 1", set_a.set_err); else n_pass++;
    n_checks++; if (hh_a !== 8'd7 || mm_a !== 8'd30 || ss_a !== 8'd0) $display("FAIL set_err_time got %0d:%0d:%0d exp 7:30:0", hh_a, mm_a, ss_a); else n_pass++;
    step();
    n_checks++; if (set_a.set_err !== 1'b0) $display("FAIL set_err_width got %b exp 0", set_a.set_err); else n_pass++;
    set_a_time(5'd24, 6'd0, 6'd0);
    n_checks++; if (set_a.set_err !== 1'b1 || hh_a !== 8'd7) $display("FAIL set_err_hour got err=%b hh=%0d exp 1 7", set_a.set_err, hh_a); else n_pass++;
  endtask

  task automatic test_set_vs_tick();
    ena_a = 1'b1;
    repeat (DIV_A - 1) step();
    // this edge would carry the tick; the load must win
    set_a_time(5'd3, 6'd4, 6'd5);
    ena_a = 1'b0;
    n_checks++; if (hh_a !== 8'd3 || mm_a !== 8'd4 || ss_a !== 8'd5) $display("FAIL set_tick_time got %0d:%0d:%0d exp 3:4:5", hh_a, mm_a, ss_a); else n_pass++;
    n_checks++; if (sec_a !== 1'b0) $display("FAIL set_tick_pulse got %b exp 0", sec_a); else n_pass++;
    // prescaler restarted: a full DIV cycles needed for the next advance
    ena_a = 1'b1;
    repeat (DIV_A - 1) step();
    n_checks++; if (ss_a !== 8'd5) $display("FAIL presc_cleared got %0d exp 5", ss_a); else n_pass++;
    step();
    ena_a = 1'b0;
    n_checks++; if (ss_a !== 8'd6 || sec_a !== 1'b1) $display("FAIL presc_restart got ss=%0d sec=%b exp 6 1", ss_a, sec_a); else n_pass++;
  endtask

  task automatic test_bcd();
    set_b.set_valid = 1'b1;
    set_b.set_hh = 5'd10;
    set_b.set_mm = 6'd45;
    set_b.set_ss = 6'd9;
    step();
    set_b.set_valid = 1'b0;
    n_checks++; if (hh_b !== 8'h10 || mm_b !== 8'h45 || ss_b !== 8'h09) $display("FAIL bcd_time got %h:%h:%h exp 10:45:09", hh_b, mm_b, ss_b); else n_pass++;
    set_b.set_valid = 1'b1;
    set_b.set_hh = 5'd19;
    set_b.set_mm = 6'd59;
    set_b.set_ss = 6'd58;
    step();
    set_b.set_valid = 1'b0;
    n_checks++; if (hh_b !== 8'h07 || pm_b !== 1'b1) $display("FAIL bcd_12h got hh=%h pm=%b exp 07 1", hh_b, pm_b); else n_pass++;
    mode24 = 1'b1;
    #1;
    n_checks++; if (hh_b !== 8'h19 || mm_b !== 8'h59 || ss_b !== 8'h58) $display("FAIL bcd_24h got %h:%h:%h exp 19:59:58", hh_b, mm_b, ss_b); else n_pass++;
    mode24 = 1'b0;
    // DIV=1: every enabled cycle advances
    ena_b = 1'b1;
    repeat (2) step();
    ena_b = 1'b0;
    n_checks++; if (hh_b !== 8'h08 || mm_b !== 8'h00 || ss_b !== 8'h00 || sec_b !== 1'b1) $display("FAIL bcd_div1 got %h:%h:%h sec=%b exp 08:00:00 1", hh_b, mm_b, ss_b, sec_b); else n_pass++;
  endtask

  task automatic test_async_reset();
    ena_a = 1'b1;
    step();
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (hh_a !== 8'd12 || mm_a !== 8'd0 || ss_a !== 8'd0 || pm_a !== 1'b1) $display("FAIL async_reset got %0d:%0d:%0d pm=%b exp 12:0:0 1", hh_a, mm_a, ss_a, pm_a); else n_pass++;
    step();
    reset = 1'b0;
    ena_a = 1'b0;
  endtask

  // ---------------- main ----------------
  initial begin
    n_checks = 0;
    n_pass = 0;
    reset = 1'b1;
    mode24 = 1'b0;
    ena_a = 1'b0;
    ena_b = 1'b0;
    alarm_en_a = 1'b0;
    alarm_hh_a = 5'd0;
    alarm_mm_a = 6'd0;
    set_a.set_valid = 1'b0;
    set_a.set_hh = 5'd0;
    set_a.set_mm = 6'd0;
    set_a.set_ss = 6'd0;
    set_b.set_valid = 1'b0;
    set_b.set_hh = 5'd0;
    set_b.set_mm = 6'd0;
    set_b.set_ss = 6'd0;

    test_reset();
    test_prescaler();
    test_day_rollover();
    test_noon();
    test_alarm();
    test_set_error();
    test_set_vs_tick();
    test_bcd();
    test_async_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
